// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream frame generator with a byte-counter payload.
//
// Produces num_frames frames of frame_len bytes (0 counts as 1). Consecutive
// frames are separated by gap_len idle cycles. Byte k of a frame carries
// (seq + k) mod 256, and seq continues across frames and runs, so the
// downstream byte stream is one unbroken counter from reset onwards.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable              level-sensitive run request
//   frame_len           bytes per frame, sampled at every frame start
//   gap_len             idle cycles after each frame, sampled at frame start
//   num_frames          frames per run (0 = unlimited), sampled at frame start
//   m_axis_*            AXI-Stream master (tdata/tkeep/tvalid/tready/tlast)
//   busy                high while sending or waiting out a gap
//   done                run finished; held until enable falls
//   frame_count         frames completed in the current run
//   fsm_state           current FSM state, for debug/observation
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. Once tvalid is raised, tdata/tkeep/tlast stay stable and tvalid
// stays high until that transfer; tvalid never drops inside a frame. tready
// is ignored while tvalid is 0.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [GAP_WIDTH-1:0]  gap_len,
    input  logic [CNT_WIDTH-1:0]  num_frames,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0]           KEEP_BYTES = 8'(KEEP_WIDTH);
    localparam logic [LEN_WIDTH-1:0] KEEP_LEN   = LEN_WIDTH'(KEEP_WIDTH);

    state_t                state_q, state_d;
    // seq_q: value of lane 0 of the current beat while sending; otherwise the
    // first byte of the next frame.
    logic [7:0]            seq_q, seq_d;
    // rem_q: bytes still to send, counting the beat currently presented.
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  start_frame;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [CNT_WIDTH-1:0]  count_inc;

    // Beat starting at byte value 'first' with 'rem' bytes left; lanes past
    // the end of the frame carry 0.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0] first,
                                                        input logic [LEN_WIDTH-1:0] rem);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (LEN_WIDTH'(i) < rem) d[8*i +: 8] = first + 8'(i);
        end
        return d;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [LEN_WIDTH-1:0] rem);
        logic [KEEP_WIDTH-1:0] k;
        k = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (LEN_WIDTH'(i) < rem) k[i] = 1'b1;
        end
        return k;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seq_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            num_q     <= '0;
            count_q   <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            num_q     <= num_d;
            count_q   <= count_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        num_d       = num_q;
        count_d     = count_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        start_frame = 1'b0;
        len_eff     = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
        count_inc   = count_q + CNT_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    count_d     = '0;
                    start_frame = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis_tready) begin
                    if (!tlast_q) begin
                        seq_d   = seq_q + KEEP_BYTES;
                        rem_d   = rem_q - KEEP_LEN;
                        tdata_d = beat_data(seq_d, rem_d);
                        tkeep_d = beat_keep(rem_d);
                        tlast_d = (rem_d <= KEEP_LEN);
                    end else begin
                        // Final beat accepted: advance the byte stream past
                        // the bytes of this beat and decide what follows.
                        count_d  = count_inc;
                        seq_d    = seq_q + 8'(rem_q);
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        if (num_q != '0 && count_inc == num_q) begin
                            state_d = DONE;
                        end else if (!enable) begin
                            state_d = IDLE;
                        end else if (gap_q == '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q - GAP_WIDTH'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (enable) begin
                        start_frame = 1'b1;
                        state_d     = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Frame start: sample the run parameters and present beat 0.
        if (start_frame) begin
            rem_d    = len_eff;
            gap_d    = gap_len;
            num_d    = num_frames;
            tdata_d  = beat_data(seq_d, len_eff);
            tkeep_d  = beat_keep(len_eff);
            tlast_d  = (len_eff <= KEEP_LEN);
            tvalid_d = 1'b1;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == SEND) || (state_q == GAP);
    assign done          = (state_q == DONE);
    assign frame_count   = count_q;
    assign fsm_state     = state_q;

endmodule
